// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: word RAM + loader port, read pipeline, response FIFO. IMEM_ERR_EN adds bad-address flagging.
// Latency: accept -> rsp_valid after LATENCY rising edges; the RAM read is combinational in the accept cycle.
// Backpressure: req_ready drops while in-flight + buffered == FIFO_DEPTH; the FIFO head holds while rsp_ready is low.

// Small synchronous FIFO with a zero-forced output when empty.
// Latency: one edge from push to visible head.
// Backpressure: pushes into a full FIFO are dropped; the caller guarantees space.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push   = wr_vld && (count != CNT_W'(DEPTH));
    assign pop    = rd_vld && rd_rdy;
    assign rd_vld = (count != '0);
    assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage carries no reset; emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end
endmodule

module imem_fetch_responder #(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    LATENCY     = 1,
    parameter int    FIFO_DEPTH  = 2,
    parameter string INIT_FILE   = "",
    localparam int   ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_instr,
    output logic              rsp_err,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data
);
    typedef struct packed {
        logic        err;
        logic [31:0] instr;
    } entry_t;

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [31:0]       ram [DEPTH_WORDS];
    logic [CNT_W-1:0]  outstanding;
    logic              acc;
    logic              pop;
    logic [ADDR_W-1:0] rd_idx;
    entry_t            rd_entry;
    entry_t            fifo_wr_dat;
    logic              fifo_wr_vld;
    entry_t            head;

    assign req_ready = (outstanding < CNT_W'(FIFO_DEPTH));
    assign acc       = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;
    assign rd_idx    = req_addr[ADDR_W+1:2];

`ifdef IMEM_ERR_EN
    logic addr_bad;
    assign addr_bad = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0);

    always_comb begin
        rd_entry       = '0;
        rd_entry.err   = addr_bad;
        rd_entry.instr = addr_bad ? 32'h0000_0000 : ram[rd_idx];
    end
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

    always_comb begin
        rd_entry       = '0;
        rd_entry.instr = ram[rd_idx];
    end
`endif

    // Read is combinational, write lands at the edge: a same-cycle collision returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) ram[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            case ({acc, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: ;
            endcase
        end
    end

    generate
        if (LATENCY == 1) begin : g_nopipe
            assign fifo_wr_vld = acc;
            assign fifo_wr_dat = rd_entry;
        end else begin : g_pipe
            logic [LATENCY-2:0] pipe_vld;
            entry_t             pipe_dat [LATENCY-1];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pipe_vld <= '0;
                    for (int i = 0; i < LATENCY - 1; i++) pipe_dat[i] <= '0;
                end else begin
                    pipe_vld[0] <= acc;
                    pipe_dat[0] <= rd_entry;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        pipe_vld[i] <= pipe_vld[i-1];
                        pipe_dat[i] <= pipe_dat[i-1];
                    end
                end
            end

            assign fifo_wr_vld = pipe_vld[LATENCY-2];
            assign fifo_wr_dat = pipe_dat[LATENCY-2];
        end
    endgenerate

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (fifo_wr_vld),
        .wr_dat (fifo_wr_dat),
        .rd_vld (rsp_valid),
        .rd_rdy (rsp_ready),
        .rd_dat (head)
    );

    assign rsp_instr = head.instr;
    assign rsp_err   = head.err;
endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: directed vector table, hand sequences for collision / reset corners,
// and randomized traffic against a queue-based reference model.
module tb_imem_fetch_responder;
    localparam int DW  = 1024;
    localparam int LAT = 1;
    localparam int FD  = 2;

    localparam logic [31:0] W0 = 32'h0050_0093;
    localparam logic [31:0] W1 = 32'h0010_0113;
    localparam logic [31:0] W2 = 32'h0020_81b3;
    localparam logic [31:0] W3 = 32'h0000_0013;
    localparam logic [31:0] W5 = 32'h1111_1111;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic        rsp_err;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;

    always #5 clk = ~clk;

    imem_fetch_responder #(
        .DEPTH_WORDS (DW),
        .LATENCY     (LAT),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_err   (rsp_err),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] mem_m [DW];

    typedef struct {
        logic [31:0] instr;
        bit          err;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc;

    typedef struct {
        bit          rv;
        logic [31:0] addr;
        bit          rr;
        bit          e_rdy;
        bit          e_vld;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
    endtask

    task automatic load(input int idx, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = 10'(idx);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        mem_m[idx] = d;
    endtask

    // Reference read: index is the word address modulo RAM size; bad addresses flag only with the macro.
    function automatic exp_t model_read(input logic [31:0] a, input int due);
        exp_t e;
        int   idx;
        idx     = int'((a >> 2) % DW);
        e.err   = 1'b0;
        e.instr = mem_m[idx];
`ifdef IMEM_ERR_EN
        if ((a % 4) != 0 || a >= 32'(4 * DW)) begin
            e.err   = 1'b1;
            e.instr = 32'h0;
        end
`endif
        e.due = due;
        return e;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "time limit expired");
    end

    initial begin
        exp_t e_a;
        exp_t e_b;

        idle();
        reset = 1'b1;
        tick();
        load(0, W0);
        load(1, W1);
        load(2, W2);
        load(3, W3);
        load(5, W5);
        tick();
        reset = 1'b0;
        tick();

        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_instr", rsp_instr, 0);
        chk("reset_rsp_err", rsp_err, 0);

        req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("first_fetch_vld", rsp_valid, 1);
        chk("first_fetch_instr", rsp_instr, W0);
        tick();
        chk("first_fetch_drained", rsp_valid, 0);

        // Streaming then backpressure, one row per cycle.
        vt.push_back('{1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0});
        vt.push_back('{1'b1, 32'h4, 1'b1, 1'b1, 1'b1, W0});
        vt.push_back('{1'b1, 32'h8, 1'b1, 1'b1, 1'b1, W1});
        vt.push_back('{1'b1, 32'hC, 1'b1, 1'b1, 1'b1, W2});
        vt.push_back('{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, W3});
        vt.push_back('{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0});
        vt.push_back('{1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0});
        vt.push_back('{1'b1, 32'h4, 1'b0, 1'b1, 1'b1, W0});
        vt.push_back('{1'b1, 32'h8, 1'b0, 1'b0, 1'b1, W0});
        vt.push_back('{1'b1, 32'h8, 1'b0, 1'b0, 1'b1, W0});
        vt.push_back('{1'b1, 32'h8, 1'b1, 1'b0, 1'b1, W0});
        vt.push_back('{1'b1, 32'h8, 1'b1, 1'b1, 1'b1, W1});
        vt.push_back('{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, W2});
        vt.push_back('{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0});

        foreach (vt[i]) begin
            req_valid = vt[i].rv;
            req_addr  = vt[i].addr;
            rsp_ready = vt[i].rr;
            chk($sformatf("vec%0d_req_ready", i), req_ready, vt[i].e_rdy);
            chk($sformatf("vec%0d_rsp_valid", i), rsp_valid, vt[i].e_vld);
            if (vt[i].e_vld) chk($sformatf("vec%0d_rsp_instr", i), rsp_instr, vt[i].e_instr);
            tick();
        end
        idle();

        // Same-word write and fetch in one cycle: old word first, new word on the repeat.
        req_valid = 1'b1; req_addr = 32'h14; rsp_ready = 1'b1;
        wr_en = 1'b1; wr_addr = 10'd5; wr_data = 32'hDEAD_BEEF;
        tick();
        wr_en = 1'b0;
        mem_m[5] = 32'hDEAD_BEEF;
        chk("collision_old_vld", rsp_valid, 1);
        chk("collision_old_word", rsp_instr, W5);
        tick();
        req_valid = 1'b0;
        chk("collision_new_word", rsp_instr, 32'hDEAD_BEEF);
        tick();
        chk("collision_drained", rsp_valid, 0);

        // Misaligned and out-of-range addresses.
        e_a = model_read(32'h0000_0002, 0);
        e_b = model_read(32'h0000_1004, 0);
        req_valid = 1'b1; req_addr = 32'h0000_0002; rsp_ready = 1'b1;
        tick();
        req_addr = 32'h0000_1004;
`ifdef IMEM_ERR_EN
        chk("misaligned_err", {rsp_err, rsp_instr}, {1'b1, 32'h0});
`else
        chk("misaligned_err", {rsp_err, rsp_instr}, {1'b0, W0});
`endif
        chk("misaligned_model", {rsp_err, rsp_instr}, {e_a.err, e_a.instr});
        tick();
        req_valid = 1'b0;
        chk("upper_bits_model", {rsp_err, rsp_instr}, {e_b.err, e_b.instr});
        tick();
        chk("bad_addr_drained", rsp_valid, 0);
        idle();

        // Reset with a full response buffer: everything must vanish.
        req_valid = 1'b1; req_addr = 32'h0;
        tick();
        req_addr = 32'h4;
        tick();
        req_valid = 1'b0;
        chk("midrst_full_ready", req_ready, 0);
        chk("midrst_full_valid", rsp_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_valid_drop", rsp_valid, 0);
        chk("midrst_ready_up", req_ready, 1);
        tick();
        reset = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("midrst_no_stale%0d", i), rsp_valid, 0);
        end
        req_valid = 1'b1; req_addr = 32'h8;
        tick();
        req_valid = 1'b0;
        chk("midrst_fresh_fetch", {rsp_valid, rsp_instr}, {1'b1, W2});
        tick();
        chk("midrst_fresh_drained", rsp_valid, 0);
        idle();

        // Randomized traffic against the queue model.
        for (int i = 0; i < 64; i++) load(i, $urandom);
        q.delete();
        cyc = 0;
        for (int i = 0; i < 2000; i++) begin
            bit          exp_vld;
            bit          exp_rdy;
            bit          rv;
            bit          rr;
            bit          we;
            logic [31:0] a;
            int          wa;
            logic [31:0] wd;

            exp_vld = (q.size() > 0) && (q[0].due <= cyc);
            exp_rdy = (q.size() < FD);
            chk("rnd_rsp_valid", rsp_valid, exp_vld);
            chk("rnd_req_ready", req_ready, exp_rdy);
            if (exp_vld) chk("rnd_rsp_data", {rsp_err, rsp_instr}, {q[0].err, q[0].instr});

            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 2) != 0);
            a  = 32'($urandom_range(0, 63) * 4);
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 15) << 12);
            we = ($urandom_range(0, 3) == 0);
            wa = $urandom_range(0, 63);
            wd = $urandom;

            req_valid = rv;
            req_addr  = rv ? a : 32'($urandom);
            rsp_ready = rr;
            wr_en     = we;
            wr_addr   = 10'(wa);
            wr_data   = wd;

            if (exp_vld && rr) void'(q.pop_front());
            if (rv && exp_rdy) q.push_back(model_read(a, cyc + LAT));
            if (we) mem_m[wa] = wd;
            tick();
            cyc++;
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
